// File: rtl/vid_fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vid_fetch_pkg
//  Description : Shared constants, FSM encoding and framebuffer address helper
//                for the display word fetcher.
//  Revision    : 1.0 - initial release
// ============================================================================
package vid_fetch_pkg;

    // Framebuffer geometry and fetch sizing
    localparam logic [17:0] ORG          = 18'h37FC0;
    localparam int          LINES        = 768;
    localparam int          WPL          = 32;
    localparam int          BURST        = 8;
    localparam int          FIFO_DEPTH   = 16;
    localparam int          TOTAL_BURSTS = LINES * WPL / BURST;

    // Derived widths
    localparam int ADDR_W      = 18;
    localparam int DATA_W      = 32;
    localparam int LINE_W      = 10;
    localparam int WORD_W      = 5;
    localparam int FIFO_AW     = $clog2(FIFO_DEPTH);
    localparam int CNT_W       = FIFO_AW + 1;
    localparam int BURST_CNT_W = $clog2(TOTAL_BURSTS + 1);
    localparam int BEAT_W      = $clog2(BURST + 1);

    // Fetch sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    // Lines are stored bottom-up, so the line index is inverted before use
    function automatic logic [ADDR_W-1:0] word_addr(input logic [LINE_W-1:0] line,
                                                    input logic [WORD_W-1:0] word);
        return ORG + {3'b000, ~line, word};
    endfunction

endpackage
`default_nettype wire

// File: rtl/vid_line_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : vid_line_fifo
//  Description : Synchronous line FIFO with clock enable, flush, occupancy
//                count and a combinational head word (zero when empty).
//  Revision    : 1.0 - initial release
// ============================================================================
module vid_line_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ce_i,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           head_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_pop;
    logic             do_push;

    // A push into a full FIFO is only legal when a pop frees a slot the same cycle
    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != FULL_CNT) || do_pop);

    // Pointer and occupancy tracking; flush empties the FIFO and wins over push/pop
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (ce_i) begin
            if (flush_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
                if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
                case ({do_push, do_pop})
                    2'b10:   count_q <= count_q + (AW+1)'(1);
                    2'b01:   count_q <= count_q - (AW+1)'(1);
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    // Storage array; no reset needed since empty entries are never presented
    always_ff @(posedge clk) begin
        if (ce_i && do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: rtl/vid_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : vid_fetch
//  Description : Memory-side responder for the display word-request port.
//                Prefetches framebuffer lines in fixed bursts into a line FIFO
//                and returns the FIFO head on each vreq pulse.
//  Options     : VID_FETCH_UNDERRUN_CNT_EN adds the saturating underrun_cnt port.
//  Revision    : 1.0 - initial release
// ============================================================================
module vid_fetch
    import vid_fetch_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic              frame_start,
    input  logic              vreq,
    output logic [DATA_W-1:0] viddata,
    output logic              mem_rd_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rvalid,
    output logic              underrun
`ifdef VID_FETCH_UNDERRUN_CNT_EN
    ,
    output logic [15:0]       underrun_cnt
`endif
);

    state_t                 state_q, state_d;
    logic                   armed_q, armed_d;
    logic [LINE_W-1:0]      line_q, line_d;
    logic [WORD_W-1:0]      word_q, word_d;
    logic [BURST_CNT_W-1:0] bursts_q, bursts_d;
    logic [BEAT_W-1:0]      reserved_q, reserved_d;
    logic [BEAT_W-1:0]      beats_q, beats_d;
    logic                   underrun_q, underrun_d;

    logic [CNT_W-1:0]       fifo_count;
    logic                   fifo_empty;
    logic [DATA_W-1:0]      fifo_head;

    logic in_issue, in_wait, in_drain;
    logic ack, beat, last_beat, push, pop, urun_evt, can_issue;

    assign in_issue  = (state_q == ST_ISSUE);
    assign in_wait   = (state_q == ST_WAIT);
    assign in_drain  = (state_q == ST_DRAIN);
    assign ack       = in_issue & mem_ack;
    assign beat      = (in_wait | in_drain) & mem_rvalid & (beats_q != '0);
    assign last_beat = beat & (beats_q == BEAT_W'(1));
    assign push      = in_wait & beat & ~frame_start;
    assign pop       = vreq & armed_q & ~fifo_empty;
    assign urun_evt  = vreq & armed_q & fifo_empty;

    // Only start a burst when the FIFO is guaranteed room for every beat
    assign can_issue = armed_q
                     & (bursts_q < BURST_CNT_W'(TOTAL_BURSTS))
                     & (((CNT_W+1)'(fifo_count) + (CNT_W+1)'(reserved_q))
                        <= (CNT_W+1)'(FIFO_DEPTH - BURST));

    vid_line_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .ce_i    (ce),
        .flush_i (frame_start),
        .push_i  (push),
        .data_i  (mem_rdata),
        .pop_i   (pop),
        .head_o  (fifo_head),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Sequencer state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else if (ce) begin
            state_q <= state_d;
        end
    end

    // Sequencer next state; a frame restart mid-burst must still swallow the in-flight beats
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (!frame_start && can_issue) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (frame_start)  state_d = mem_ack ? ST_DRAIN : ST_IDLE;
                else if (mem_ack) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (last_beat)        state_d = ST_IDLE;
                else if (frame_start) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (last_beat || (beats_q == '0)) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Sequencer outputs: request and address are only presented in ISSUE
    always_comb begin
        mem_rd_req = 1'b0;
        mem_addr   = '0;
        if (in_issue) begin
            mem_rd_req = 1'b1;
            mem_addr   = word_addr(line_q, word_q);
        end
    end

    // Address, reservation, beat and underrun next-state logic
    always_comb begin
        armed_d    = armed_q;
        line_d     = line_q;
        word_d     = word_q;
        bursts_d   = bursts_q;
        reserved_d = reserved_q;
        underrun_d = underrun_q;
        beats_d    = beats_q;

        if (frame_start) begin
            armed_d    = 1'b1;
            line_d     = '0;
            word_d     = '0;
            bursts_d   = '0;
            reserved_d = '0;
            underrun_d = 1'b0;
        end else begin
            if (ack) begin
                bursts_d   = bursts_q + BURST_CNT_W'(1);
                reserved_d = reserved_q + BEAT_W'(BURST);
                if (word_q == WORD_W'(WPL - BURST)) begin
                    word_d = '0;
                    line_d = line_q + LINE_W'(1);
                end else begin
                    word_d = word_q + WORD_W'(BURST);
                end
            end else if (push) begin
                reserved_d = reserved_q - BEAT_W'(1);
            end
            if (urun_evt) underrun_d = 1'b1;
        end

        // Outstanding beats follow the memory side even across a frame restart
        if (ack)       beats_d = BEAT_W'(BURST);
        else if (beat) beats_d = beats_q - BEAT_W'(1);
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            armed_q    <= 1'b0;
            line_q     <= '0;
            word_q     <= '0;
            bursts_q   <= '0;
            reserved_q <= '0;
            beats_q    <= '0;
            underrun_q <= 1'b0;
        end else if (ce) begin
            armed_q    <= armed_d;
            line_q     <= line_d;
            word_q     <= word_d;
            bursts_q   <= bursts_d;
            reserved_q <= reserved_d;
            beats_q    <= beats_d;
            underrun_q <= underrun_d;
        end
    end

`ifdef VID_FETCH_UNDERRUN_CNT_EN
    logic [15:0] urun_cnt_q;

    // Saturating count of underrun events, cleared at each frame start
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            urun_cnt_q <= '0;
        end else if (ce) begin
            if (frame_start) begin
                urun_cnt_q <= '0;
            end else if (urun_evt && (urun_cnt_q != 16'hFFFF)) begin
                urun_cnt_q <= urun_cnt_q + 16'd1;
            end
        end
    end

    assign underrun_cnt = urun_cnt_q;
`endif

    assign viddata  = fifo_head;
    assign underrun = underrun_q;

endmodule
`default_nettype wire

// File: tb/tb_vid_fetch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_vid_fetch
//  Description : Directed self-checking bench for vid_fetch.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vid_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce;
    logic        frame_start;
    logic        vreq;
    logic [31:0] viddata;
    logic        mem_rd_req;
    logic [17:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;
    logic        underrun;
`ifdef VID_FETCH_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vid_fetch dut (
        .clk         (clk),
        .rst         (rst),
        .ce          (ce),
        .frame_start (frame_start),
        .vreq        (vreq),
        .viddata     (viddata),
        .mem_rd_req  (mem_rd_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .mem_rvalid  (mem_rvalid),
        .underrun    (underrun)
`ifdef VID_FETCH_UNDERRUN_CNT_EN
        ,
        .underrun_cnt(underrun_cnt)
`endif
    );

    // Beat payload: generation tag in the top byte, word address in the bottom bits
    function automatic logic [31:0] pix(input logic [17:0] a, input logic [7:0] g);
        return {g, 6'b000000, a};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for a request, hold it one cycle without ack, then accept it
    task automatic req_and_ack(output bit ok, output logic [17:0] addr, output bit held);
        int n;
        n    = 0;
        ok   = 1'b0;
        held = 1'b0;
        addr = '0;
        while (n < 40 && !mem_rd_req) begin
            tick();
            n++;
        end
        if (!mem_rd_req) return;
        ok   = 1'b1;
        addr = mem_addr;
        tick();
        held = mem_rd_req && (mem_addr == addr);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
    endtask

    task automatic send_beats(input logic [17:0] base, input logic [7:0] g, input int first, input int n);
        for (int k = 0; k < n; k++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = pix(base + 18'(first + k), g);
            tick();
        end
        mem_rvalid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; ce = 1'b1; frame_start = 1'b0; vreq = 1'b1;
        mem_ack = 1'b0; mem_rdata = '0; mem_rvalid = 1'b0;
        tick(); tick();
        checks++; if (mem_rd_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", mem_rd_req); end
        checks++; if (mem_addr !== 18'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0", mem_addr); end
        checks++; if (viddata !== 32'h0) begin errors++; $display("FAIL reset_viddata: got %h expected 0", viddata); end
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun: got %b expected 0", underrun); end
        rst = 1'b1;
        repeat (5) tick();
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL disarmed_vreq_underrun: got %b expected 0", underrun); end
        checks++; if (mem_rd_req !== 1'b0) begin errors++; $display("FAIL disarmed_req: got %b expected 0", mem_rd_req); end
`ifdef VID_FETCH_UNDERRUN_CNT_EN
        checks++; if (underrun_cnt !== 16'd0) begin errors++; $display("FAIL disarmed_cnt: got %0d expected 0", underrun_cnt); end
`endif
        vreq = 1'b0;
    endtask

    task automatic test_first_bursts();
        bit ok, held;
        logic [17:0] a;
        int hits;
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        req_and_ack(ok, a, held);
        checks++; if (!ok || !held || a !== 18'h3FFA0) begin errors++; $display("FAIL first_addr: got %h (ok=%b held=%b) expected 3ffa0", a, ok, held); end
        send_beats(a, 8'h01, 0, 8);
        req_and_ack(ok, a, held);
        checks++; if (!ok || !held || a !== 18'h3FFA8) begin errors++; $display("FAIL second_addr: got %h (ok=%b held=%b) expected 3ffa8", a, ok, held); end
        send_beats(a, 8'h01, 0, 8);
        hits = 0;
        repeat (20) begin
            if (mem_rd_req) hits++;
            tick();
        end
        checks++; if (hits != 0) begin errors++; $display("FAIL full_fifo_no_req: got %0d req cycles expected 0", hits); end
        checks++; if (viddata !== pix(18'h3FFA0, 8'h01)) begin errors++; $display("FAIL first_head: got %h expected %h", viddata, pix(18'h3FFA0, 8'h01)); end
    endtask

    task automatic test_readout();
        bit ok, held;
        logic [17:0] a;
        logic [17:0] exp_next [4];
        exp_next = '{18'h3FFB0, 18'h3FFB8, 18'h3FF80, 18'h3FF88};
        for (int blk = 0; blk < 4; blk++) begin
            for (int w = 0; w < 8; w++) begin
                checks++;
                if (viddata !== pix(18'h3FFA0 + 18'(blk * 8 + w), 8'h01)) begin
                    errors++;
                    $display("FAIL readout_word%0d: got %h expected %h", blk * 8 + w, viddata, pix(18'h3FFA0 + 18'(blk * 8 + w), 8'h01));
                end
                vreq = 1'b1; tick(); vreq = 1'b0;
            end
            req_and_ack(ok, a, held);
            checks++; if (!ok || !held || a !== exp_next[blk]) begin errors++; $display("FAIL readout_next_addr%0d: got %h expected %h", blk, a, exp_next[blk]); end
            send_beats(a, 8'h01, 0, 8);
        end
    endtask

    task automatic test_underrun();
        for (int w = 0; w < 16; w++) begin
            checks++;
            if (viddata !== pix(18'h3FF80 + 18'(w), 8'h01)) begin
                errors++;
                $display("FAIL line1_word%0d: got %h expected %h", w, viddata, pix(18'h3FF80 + 18'(w), 8'h01));
            end
            vreq = 1'b1; tick(); vreq = 1'b0;
        end
        checks++; if (viddata !== 32'h0) begin errors++; $display("FAIL empty_head: got %h expected 0", viddata); end
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL underrun_before: got %b expected 0", underrun); end
        vreq = 1'b1; tick(); vreq = 1'b0;
        checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL underrun_set: got %b expected 1", underrun); end
`ifdef VID_FETCH_UNDERRUN_CNT_EN
        checks++; if (underrun_cnt !== 16'd1) begin errors++; $display("FAIL underrun_cnt1: got %0d expected 1", underrun_cnt); end
`endif
        vreq = 1'b1; tick(); tick(); vreq = 1'b0;
`ifdef VID_FETCH_UNDERRUN_CNT_EN
        checks++; if (underrun_cnt !== 16'd3) begin errors++; $display("FAIL underrun_cnt3: got %0d expected 3", underrun_cnt); end
`endif
        checks++; if (viddata !== 32'h0) begin errors++; $display("FAIL underrun_viddata: got %h expected 0", viddata); end
        checks++; if (mem_rd_req !== 1'b1 || mem_addr !== 18'h3FF90) begin errors++; $display("FAIL pending_req: got req=%b addr=%h expected req=1 addr=3ff90", mem_rd_req, mem_addr); end
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        checks++; if (mem_rd_req !== 1'b0) begin errors++; $display("FAIL issue_cancel: got req=%b expected 0", mem_rd_req); end
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL underrun_clear: got %b expected 0", underrun); end
`ifdef VID_FETCH_UNDERRUN_CNT_EN
        checks++; if (underrun_cnt !== 16'd0) begin errors++; $display("FAIL underrun_cnt_clear: got %0d expected 0", underrun_cnt); end
`endif
    endtask

    task automatic test_abort();
        bit ok, held;
        logic [17:0] a;
        int hits;
        req_and_ack(ok, a, held);
        checks++; if (!ok || !held || a !== 18'h3FFA0) begin errors++; $display("FAIL restart_addr: got %h expected 3ffa0", a); end
        send_beats(a, 8'h0B, 0, 3);
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        hits = 0;
        for (int k = 3; k < 8; k++) begin
            if (mem_rd_req) hits++;
            mem_rvalid = 1'b1;
            mem_rdata  = pix(a + 18'(k), 8'h0B);
            tick();
        end
        mem_rvalid = 1'b0;
        checks++; if (hits != 0) begin errors++; $display("FAIL drain_no_req: got %0d req cycles expected 0", hits); end
        checks++; if (viddata !== 32'h0) begin errors++; $display("FAIL drain_fifo_empty: got %h expected 0", viddata); end
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL drain_underrun: got %b expected 0", underrun); end
        req_and_ack(ok, a, held);
        checks++; if (!ok || !held || a !== 18'h3FFA0) begin errors++; $display("FAIL after_drain_addr: got %h expected 3ffa0", a); end
        send_beats(a, 8'h02, 0, 8);
        checks++; if (viddata !== pix(18'h3FFA0, 8'h02)) begin errors++; $display("FAIL after_drain_head: got %h expected %h", viddata, pix(18'h3FFA0, 8'h02)); end
    endtask

    task automatic test_ce_hold();
        bit ok, held;
        logic [17:0] a;
        int hold_bad, hits;
        req_and_ack(ok, a, held);
        checks++; if (!ok || !held || a !== 18'h3FFA8) begin errors++; $display("FAIL ce_burst_addr: got %h expected 3ffa8", a); end
        send_beats(a, 8'h02, 0, 3);
        ce = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = pix(a + 18'd3, 8'h02);
        hold_bad = 0;
        hits = 0;
        for (int c = 0; c < 10; c++) begin
            vreq = (c % 2 == 0);
            if (viddata !== pix(18'h3FFA0, 8'h02)) hold_bad++;
            if (mem_rd_req) hits++;
            tick();
        end
        vreq = 1'b0;
        mem_rvalid = 1'b0;
        ce = 1'b1;
        checks++; if (hold_bad != 0) begin errors++; $display("FAIL ce_hold_head: got %0d changed cycles expected 0", hold_bad); end
        checks++; if (hits != 0) begin errors++; $display("FAIL ce_hold_req: got %0d req cycles expected 0", hits); end
        send_beats(a, 8'h02, 3, 5);
        for (int w = 0; w < 16; w++) begin
            checks++;
            if (viddata !== pix(18'h3FFA0 + 18'(w), 8'h02)) begin
                errors++;
                $display("FAIL ce_order_word%0d: got %h expected %h", w, viddata, pix(18'h3FFA0 + 18'(w), 8'h02));
            end
            vreq = 1'b1; tick(); vreq = 1'b0;
        end
    endtask

    task automatic test_full_frame();
        logic [9:0]  L;
        logic [4:0]  W;
        logic [17:0] exp_a, cur, prev, last;
        int issued, bad_addr, bad_data, hits, n;
        bit timeout;
        L = '0; W = '0; cur = '0; prev = '0; last = '0;
        issued = 0; bad_addr = 0; bad_data = 0; timeout = 1'b0;
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        for (int b = 0; b < 3072; b++) begin
            n = 0;
            while (n < 20 && !mem_rd_req) begin
                tick();
                n++;
            end
            if (!mem_rd_req) begin
                timeout = 1'b1;
                break;
            end
            issued++;
            exp_a = 18'h37FC0 + {3'b000, ~L, W};
            if (mem_addr !== exp_a) bad_addr++;
            cur  = mem_addr;
            last = cur;
            mem_ack = 1'b1; tick(); mem_ack = 1'b0;
            for (int k = 0; k < 8; k++) begin
                if (b > 0 && viddata !== pix(prev + 18'(k), 8'h03)) bad_data++;
                vreq       = (b > 0);
                mem_rvalid = 1'b1;
                mem_rdata  = pix(cur + 18'(k), 8'h03);
                tick();
            end
            mem_rvalid = 1'b0;
            vreq       = 1'b0;
            prev = cur;
            if (W == 5'd24) begin
                W = '0;
                L = L + 10'd1;
            end else begin
                W = W + 5'd8;
            end
        end
        checks++; if (timeout) begin errors++; $display("FAIL frame_timeout: got timeout after %0d bursts expected 3072", issued); end
        checks++; if (issued != 3072) begin errors++; $display("FAIL frame_bursts: got %0d expected 3072", issued); end
        checks++; if (bad_addr != 0) begin errors++; $display("FAIL frame_addrs: got %0d bad expected 0", bad_addr); end
        checks++; if (bad_data != 0) begin errors++; $display("FAIL frame_data: got %0d bad expected 0", bad_data); end
        checks++; if (last !== 18'h39FD8) begin errors++; $display("FAIL frame_last_addr: got %h expected 39fd8", last); end
        hits = 0;
        repeat (40) begin
            if (mem_rd_req) hits++;
            tick();
        end
        checks++; if (hits != 0) begin errors++; $display("FAIL frame_end_no_req: got %0d req cycles expected 0", hits); end
        bad_data = 0;
        for (int k = 0; k < 8; k++) begin
            if (viddata !== pix(prev + 18'(k), 8'h03)) bad_data++;
            vreq = 1'b1; tick(); vreq = 1'b0;
        end
        repeat (20) begin
            if (mem_rd_req) hits++;
            tick();
        end
        checks++; if (bad_data != 0 || hits != 0) begin errors++; $display("FAIL frame_tail: got %0d bad words %0d req cycles expected 0 0", bad_data, hits); end
        checks++; if (viddata !== 32'h0) begin errors++; $display("FAIL frame_tail_empty: got %h expected 0", viddata); end
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        n = 0;
        while (n < 20 && !mem_rd_req) begin
            tick();
            n++;
        end
        checks++; if (mem_rd_req !== 1'b1 || mem_addr !== 18'h3FFA0) begin errors++; $display("FAIL new_frame_addr: got req=%b addr=%h expected req=1 addr=3ffa0", mem_rd_req, mem_addr); end
    endtask

    initial begin
        test_reset();
        test_first_bursts();
        test_readout();
        test_underrun();
        test_abort();
        test_ce_hold();
        test_full_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
